// File: rtl/dmem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dmem_ctrl_pkg : access-mode encodings and helpers shared by the data-memory
// controller and its RAM.
// ---------------------------------------------------------------------------
`default_nettype none

package dmem_ctrl_pkg;

  localparam int              MEM_MODE_WIDTH = 3;
  localparam logic            RST_ACTIVE     = 1'b1;

  // funct3 encodings of the load/store width
  localparam logic [MEM_MODE_WIDTH-1:0] MEM_BYTE  = 3'b000;
  localparam logic [MEM_MODE_WIDTH-1:0] MEM_HALF  = 3'b001;
  localparam logic [MEM_MODE_WIDTH-1:0] MEM_WORD  = 3'b010;
  localparam logic [MEM_MODE_WIDTH-1:0] MEM_BYTEU = 3'b100;
  localparam logic [MEM_MODE_WIDTH-1:0] MEM_HALFU = 3'b101;

  // Halves must sit on even bytes, words on 4-byte boundaries.
  function automatic logic addr_misaligned(input logic [MEM_MODE_WIDTH-1:0] mode,
                                           input logic [1:0]                offs);
    case (mode)
      MEM_HALF, MEM_HALFU: return offs[0];
      MEM_WORD:            return (offs != 2'b00);
      default:             return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_ram.sv
// ---------------------------------------------------------------------------
// dmem_ram : DEPTH x 32 synchronous RAM, byte-write enables, registered read.
// Contents are not reset.
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane writes and registered read, one cycle read latency
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl : MEM-stage load/store responder. Latches one aligned request,
// waits WAIT_CYCLES, performs it on dmem_ram, returns formatted load data.
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read_i,
  input  logic                      mem_write_i,
  input  logic [MEM_MODE_WIDTH-1:0] mem_mode_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      stall_o,
  output logic [31:0]               rdata_o,
  output logic                      rdata_valid_o,
  output logic                      misalign_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                    state;
  logic [3:0]                wait_cnt;
  logic [AW-1:0]             idx_q;
  logic [1:0]                off_q;
  logic [MEM_MODE_WIDTH-1:0] mode_q;
  logic                      read_q;
  logic [31:0]               wdata_q;
  logic [3:0]                be_q;
  logic [31:0]               rdata_q;

  logic        req;
  logic        accept;
  logic        fire;
  logic [3:0]  be_n;
  logic [31:0] lane_n;
  logic [31:0] ram_rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] fmt;
  logic        unused_addr;

  // Address bits above the RAM index are ignored, so accesses wrap
  assign unused_addr = ^addr_i[31:AW+2];

  assign req        = mem_read_i | mem_write_i;
  assign misalign_o = (state == IDLE) && req && addr_misaligned(mem_mode_i, addr_i[1:0]);
  assign accept     = (state == IDLE) && req && !misalign_o;
  assign stall_o    = accept || (state == ACCESS);
  assign fire       = (state == ACCESS) && (wait_cnt == 4'd0);

  // Byte enables and lane replication of right-aligned store data
  always_comb begin
    be_n   = 4'b1111;
    lane_n = wdata_i;
    case (mem_mode_i)
      MEM_BYTE, MEM_BYTEU: begin
        be_n   = 4'b0001 << addr_i[1:0];
        lane_n = {4{wdata_i[7:0]}};
      end
      MEM_HALF, MEM_HALFU: begin
        be_n   = 4'b0011 << addr_i[1:0];
        lane_n = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatter: pick lane by latched offset, then extend per mode
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = ram_rdata[7:0];
      2'd1:    byte_sel = ram_rdata[15:8];
      2'd2:    byte_sel = ram_rdata[23:16];
      default: byte_sel = ram_rdata[31:24];
    endcase
    half_sel = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (mode_q)
      MEM_BYTE:  fmt = {{24{byte_sel[7]}}, byte_sel};
      MEM_BYTEU: fmt = {24'd0, byte_sel};
      MEM_HALF:  fmt = {{16{half_sel[15]}}, half_sel};
      MEM_HALFU: fmt = {16'd0, half_sel};
      default:   fmt = ram_rdata;
    endcase
  end

  // Load data is shown live in RESP and held afterwards
  assign rdata_valid_o = (state == RESP) && read_q;
  assign rdata_o       = rdata_valid_o ? fmt : rdata_q;

  // Control FSM with request latches and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ACTIVE) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      idx_q    <= '0;
      off_q    <= 2'd0;
      mode_q   <= MEM_WORD;
      read_q   <= 1'b0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      rdata_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q    <= addr_i[AW+1:2];
            off_q    <= addr_i[1:0];
            mode_q   <= mem_mode_i;
            read_q   <= mem_read_i;
            wdata_q  <= lane_n;
            be_q     <= be_n;
            wait_cnt <= 4'(WAIT_CYCLES);
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          else                  state    <= RESP;
        end
        RESP: begin
          if (read_q) rdata_q <= fmt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    ((fire && !read_q) ? be_q : 4'b0000),
    .re    (fire && read_q),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

`default_nettype wire
